// File: rtl/sram_port_arbiter.sv
// Two-master sram-like port arbiter: alternating priority under contention, grant lock
// until accept, and an in-order source-tag FIFO that routes responses back.
module sram_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_spurious
);

  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t               state, state_nxt;
  logic                 last_src;
  logic [MAX_OUTST-1:0] tag_q;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 gnt_i, gnt_d;
  logic                 fifo_full, fifo_empty;
  logic                 accept, pop, head;

  assign fifo_full  = (count == CNT_W'(MAX_OUTST));
  assign fifo_empty = (count == '0);

  // Grant: lock holds the owner; in IDLE the master that did not win last gets priority
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
      case (state)
        LOCK_I:  gnt_i = 1'b1;
        LOCK_D:  gnt_d = 1'b1;
        default: begin
          if (inst_req && data_req) begin
            gnt_d = !last_src;
            gnt_i = last_src;
          end else begin
            gnt_i = inst_req;
            gnt_d = data_req;
          end
        end
      endcase
    end
  end

  // Request mux toward the slave
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (gnt_i) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wstrb = inst_wstrb;
      mem_wdata = inst_wdata;
    end else if (gnt_d) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wstrb = data_wstrb;
      mem_wdata = data_wdata;
    end
  end

  assign mem_req      = ((gnt_i && inst_req) || (gnt_d && data_req)) && !fifo_full;
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && gnt_i;
  assign data_addr_ok = accept && gnt_d;

  assign head         = tag_q[rd_ptr];
  assign pop          = mem_data_ok && !fifo_empty && !reset;
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Next grant state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req && !mem_addr_ok) state_nxt = gnt_d ? LOCK_D : LOCK_I;
      LOCK_I:  if (accept || !inst_req) state_nxt = IDLE;
      LOCK_D:  if (accept || !data_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_src     <= 1'b0;
      tag_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_spurious <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_src      <= gnt_d;
        tag_q[wr_ptr] <= gnt_d;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem_data_ok && fifo_empty) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-cycle vector table plus a pipelined contention stream.
module tb_sram_port_arbiter;

  localparam logic [31:0] IA  = 32'h1c00_0000;
  localparam logic [31:0] DA  = 32'h0000_1000;
  localparam logic [31:0] IWD = 32'h1111_2222;
  localparam logic [31:0] DWD = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, data_addr, mem_addr;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_wdata, data_wdata, mem_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_spurious;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_spurious(err_spurious)
  );

  // sel: 0 = nothing granted, 1 = inst fields on mem_*, 2 = data fields on mem_*
  typedef struct {
    logic        rst, ireq, dreq, dwr, maok, mdok;
    logic [31:0] rdata;
    logic        e_mreq;
    int          sel;
    logic        e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, ireq, dreq, dwr, maok, mdok,
                              input logic [31:0] rdata, input logic e_mreq, input int sel,
                              input logic e_iaok, e_daok, e_idok, e_ddok, e_err);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwr = dwr; v.maok = maok; v.mdok = mdok;
    v.rdata = rdata; v.e_mreq = e_mreq; v.sel = sel; v.e_iaok = e_iaok; v.e_daok = e_daok;
    v.e_idok = e_idok; v.e_ddok = e_ddok; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_strb;
    logic [1:0]  e_size;
    logic        e_wr;
    logic        last_d;
    logic        q[$];
    logic        exp_d, h;

    reset = 1'b1;
    inst_req = 0; data_req = 0; inst_wr = 0; data_wr = 0;
    inst_size = 2'd2; data_size = 2'd1;
    inst_addr = IA; data_addr = DA;
    inst_wstrb = 4'h3; data_wstrb = 4'hf;
    inst_wdata = IWD; data_wdata = DWD;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    //                  rst i d wr aok dok rdata         mreq sel iaok daok idok ddok err
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h0,         0,   0,  0,   0,   0,   0,   0)); // 0 reset gates all
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   0)); // 1 inst read accept
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0,   0,  0,   0,   0,   0,   0)); // 2
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h02800c0c,  0,   0,  0,   0,   1,   0,   0)); // 3 inst response
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,         1,   2,  0,   1,   0,   0,   0)); // 4 contention: D
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   0)); // 5 I
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,         1,   2,  0,   1,   0,   0,   0)); // 6 D
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   0)); // 7 I -> full
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 32'h11,        0,   2,  0,   0,   0,   1,   0)); // 8 full, pop D
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,         1,   2,  0,   1,   0,   0,   0)); // 9 slot free again
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h22,        0,   0,  0,   0,   1,   0,   0)); // 10 drain I
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h23,        0,   0,  0,   0,   0,   1,   0)); // 11 D
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h24,        0,   0,  0,   0,   1,   0,   0)); // 12 I
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h25,        0,   0,  0,   0,   0,   1,   0)); // 13 D
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,         1,   2,  0,   0,   0,   0,   0)); // 14 data write stalled
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,         1,   2,  0,   0,   0,   0,   0)); // 15 locked to D
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,         1,   2,  0,   0,   0,   0,   0)); // 16
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 32'h0,         1,   2,  0,   1,   0,   0,   0)); // 17 D accepted
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   0)); // 18 inst next
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h30,        0,   0,  0,   0,   0,   1,   0)); // 19 pop D
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 32'h0,         1,   2,  0,   1,   0,   0,   0)); // 20 queue = I,D
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h33,        1,   1,  1,   0,   1,   0,   0)); // 21 push+pop
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h34,        0,   0,  0,   0,   0,   1,   0)); // 22 D
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h35,        0,   0,  0,   0,   1,   0,   0)); // 23 I (count was 2)
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h36,        0,   0,  0,   0,   0,   0,   0)); // 24 spurious
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0,   0,  0,   0,   0,   0,   1)); // 25 sticky err
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   1)); // 26
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 32'h0,         1,   2,  0,   1,   0,   0,   1)); // 27
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   1)); // 28 3 outstanding
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,         1,   2,  0,   0,   0,   0,   1)); // 29 lock D
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 32'h40,        0,   0,  0,   0,   0,   0,   1)); // 30 reset
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         1,   1,  1,   0,   0,   0,   0)); // 31 IDLE, err clear
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h44,        0,   0,  0,   0,   1,   0,   0)); // 32 inst response
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h45,        0,   0,  0,   0,   0,   0,   0)); // 33 old tags gone
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0,   0,  0,   0,   0,   0,   1)); // 34

    foreach (vecs[i]) begin
      @(posedge clk);
      #2;
      reset = vecs[i].rst; inst_req = vecs[i].ireq; data_req = vecs[i].dreq;
      data_wr = vecs[i].dwr; mem_addr_ok = vecs[i].maok; mem_data_ok = vecs[i].mdok;
      mem_rdata = vecs[i].rdata;
      #3;
      e_addr  = (vecs[i].sel == 1) ? IA  : (vecs[i].sel == 2) ? DA  : 32'h0;
      e_wdata = (vecs[i].sel == 1) ? IWD : (vecs[i].sel == 2) ? DWD : 32'h0;
      e_strb  = (vecs[i].sel == 1) ? 4'h3 : (vecs[i].sel == 2) ? 4'hf : 4'h0;
      e_size  = (vecs[i].sel == 1) ? 2'd2 : (vecs[i].sel == 2) ? 2'd1 : 2'd0;
      e_wr    = (vecs[i].sel == 2) ? vecs[i].dwr : 1'b0;
      chk("mem_req",      i, 32'(mem_req),      32'(vecs[i].e_mreq));
      chk("mem_addr",     i, mem_addr,          e_addr);
      chk("mem_wdata",    i, mem_wdata,         e_wdata);
      chk("mem_wstrb",    i, 32'(mem_wstrb),    32'(e_strb));
      chk("mem_size",     i, 32'(mem_size),     32'(e_size));
      chk("mem_wr",       i, 32'(mem_wr),       32'(e_wr));
      chk("inst_addr_ok", i, 32'(inst_addr_ok), 32'(vecs[i].e_iaok));
      chk("data_addr_ok", i, 32'(data_addr_ok), 32'(vecs[i].e_daok));
      chk("inst_data_ok", i, 32'(inst_data_ok), 32'(vecs[i].e_idok));
      chk("data_data_ok", i, 32'(data_data_ok), 32'(vecs[i].e_ddok));
      chk("err_spurious", i, 32'(err_spurious), 32'(vecs[i].e_err));
      chk("inst_rdata",   i, inst_rdata,        vecs[i].rdata);
      chk("data_rdata",   i, data_rdata,        vecs[i].rdata);
    end

    // Pipelined contention: accept every cycle, each response arrives one cycle after its accept
    @(posedge clk); #2;
    reset = 1'b1; inst_req = 0; data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    last_d = 1'b0;
    for (int c = 0; c < 8; c++) begin
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = (c > 0); mem_rdata = 32'(c);
      #3;
      exp_d = !last_d;
      chk("stream_daok", c, 32'(data_addr_ok), 32'(exp_d));
      chk("stream_iaok", c, 32'(inst_addr_ok), 32'(!exp_d));
      if (c > 0) begin
        h = q.pop_front();
        chk("stream_idok", c, 32'(inst_data_ok), 32'(!h));
        chk("stream_ddok", c, 32'(data_data_ok), 32'(h));
      end
      q.push_back(exp_d);
      last_d = exp_d;
      @(posedge clk); #2;
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #3;
    h = q.pop_front();
    chk("stream_drain_idok", 8, 32'(inst_data_ok), 32'(!h));
    chk("stream_drain_ddok", 8, 32'(data_data_ok), 32'(h));
    @(posedge clk); #2;
    mem_data_ok = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
